// File: rtl/scan_pkg.sv
// Shared types and decode helper for the scan/direct one-hot strobe decoder.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIRECT     = 2'd1,
    SCAN_DRIVE = 2'd2,
    SCAN_GAP   = 2'd3
  } state_e;

  // Widest supported decode is 6 -> 64; callers truncate to their own N.
  function automatic logic [63:0] onehot(input logic [5:0] idx, input int n);
    onehot = '0;
    if (int'(idx) < n) onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W -> 2^SEL_W one-hot decoder.
module onehot_dec
  import scan_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] d
);

  localparam int N = 1 << SEL_W;

  assign d = N'(onehot(6'(sel), N));

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder: host-indexed direct mode or autonomous scan with
// programmable dwell and break-before-make blanking.
module scan_decoder
  import scan_pkg::*;
#(
  parameter int SEL_W = 4,
  parameter int DWELL = 8,
  parameter int GAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_vld,
  output logic [(1<<SEL_W)-1:0] d,
  output logic [SEL_W-1:0]      idx,
  output logic                  active,
  output logic                  wrap
);

  localparam int N     = 1 << SEL_W;
  localparam int CNT_W = $clog2(DWELL + GAP + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       d_q, d_d, dec;
  logic               active_q, active_d;
  logic               wrap_q, wrap_d;
  logic               drive;

  // Decoding the next index keeps d registered with no extra pipeline stage.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel (idx_d),
    .d   (dec)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    drive   = active_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      drive   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (mode) begin
            state_d = SCAN_DRIVE;
            idx_d   = '0;
            drive   = 1'b1;
          end else begin
            state_d = DIRECT;
            drive   = 1'b0;
          end
        end
        DIRECT: begin
          if (sel_vld) begin
            idx_d = sel;
            drive = 1'b1;
          end
        end
        SCAN_DRIVE: begin
          if (cnt_q == CNT_W'(DWELL - 1)) begin
            cnt_d = '0;
            if (GAP > 0) begin
              state_d = SCAN_GAP;
              drive   = 1'b0;
            end else begin
              idx_d  = idx_q + SEL_W'(1);
              wrap_d = (idx_q == {SEL_W{1'b1}});
              drive  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SCAN_GAP: begin
          // idx holds through the blank; it advances only as the next strobe starts
          if (cnt_q == CNT_W'(GAP - 1)) begin
            cnt_d   = '0;
            state_d = SCAN_DRIVE;
            idx_d   = idx_q + SEL_W'(1);
            wrap_d  = (idx_q == {SEL_W{1'b1}});
            drive   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign d_d      = drive ? dec : '0;
  assign active_d = drive;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      d_q      <= '0;
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      d_q      <= d_d;
      active_q <= active_d;
      wrap_q   <= wrap_d;
    end
  end

  assign d      = d_q;
  assign idx    = idx_q;
  assign active = active_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: four configurations share one stimulus stream and are
// checked every cycle against a time-based model, plus literal expectations.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       sel_vld = 1'b0;
  logic [5:0] sel = '0;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // a: 2/3/1  b: 2/3/0  c: 1/1/0  e: 6/1/0  (SEL_W/DWELL/GAP)
  logic [3:0]  d_a, d_b;
  logic [1:0]  d_c;
  logic [63:0] d_e;
  logic [1:0]  idx_a, idx_b;
  logic [0:0]  idx_c;
  logic [5:0]  idx_e;
  logic        act_a, act_b, act_c, act_e;
  logic        wrap_a, wrap_b, wrap_c, wrap_e;

  scan_decoder #(.SEL_W(2), .DWELL(3), .GAP(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[1:0]), .sel_vld(sel_vld),
    .d(d_a), .idx(idx_a), .active(act_a), .wrap(wrap_a));
  scan_decoder #(.SEL_W(2), .DWELL(3), .GAP(0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[1:0]), .sel_vld(sel_vld),
    .d(d_b), .idx(idx_b), .active(act_b), .wrap(wrap_b));
  scan_decoder #(.SEL_W(1), .DWELL(1), .GAP(0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[0:0]), .sel_vld(sel_vld),
    .d(d_c), .idx(idx_c), .active(act_c), .wrap(wrap_c));
  scan_decoder #(.SEL_W(6), .DWELL(1), .GAP(0)) u_e (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .sel_vld(sel_vld),
    .d(d_e), .idx(idx_e), .active(act_e), .wrap(wrap_e));

  logic [63:0] dut_d   [4];
  logic [5:0]  dut_idx [4];
  logic        dut_act [4];
  logic        dut_wrap[4];
  assign dut_d[0] = 64'(d_a);  assign dut_idx[0] = 6'(idx_a);
  assign dut_d[1] = 64'(d_b);  assign dut_idx[1] = 6'(idx_b);
  assign dut_d[2] = 64'(d_c);  assign dut_idx[2] = 6'(idx_c);
  assign dut_d[3] = d_e;       assign dut_idx[3] = idx_e;
  assign dut_act[0] = act_a;   assign dut_wrap[0] = wrap_a;
  assign dut_act[1] = act_b;   assign dut_wrap[1] = wrap_b;
  assign dut_act[2] = act_c;   assign dut_wrap[2] = wrap_c;
  assign dut_act[3] = act_e;   assign dut_wrap[3] = wrap_e;

  // Model: md 0=idle 1=direct 2=scan; in scan everything follows from t, the
  // number of edges since scan entry.
  int          NN[4] = '{4, 4, 2, 64};
  int          DW[4] = '{3, 3, 1, 1};
  int          GP[4] = '{1, 0, 0, 0};
  int          md[4], t[4], m_idx[4];
  logic [63:0] m_d[4];
  logic        m_wrap[4];

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      md[k] = 0; t[k] = 0; m_idx[k] = 0; m_d[k] = '0; m_wrap[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    logic [63:0] one;
    int w, per, ph, slot;
    one = 64'd1;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++) begin
        m_wrap[k] = 1'b0;
        if (!en) begin
          md[k] = 0;
          m_d[k] = '0;
        end else begin
          case (md[k])
            0: begin
              if (mode) begin md[k] = 2; t[k] = 0; end
              else begin md[k] = 1; m_d[k] = '0; end
            end
            1: if (sel_vld) begin
              m_idx[k] = int'(sel) % NN[k];
              m_d[k]   = one << m_idx[k];
            end
            default: t[k]++;
          endcase
          if (md[k] == 2) begin
            w    = DW[k] + GP[k];
            per  = NN[k] * w;
            ph   = t[k] % per;
            slot = ph / w;
            m_idx[k]  = slot;
            m_d[k]    = ((ph % w) < DW[k]) ? (one << slot) : 64'd0;
            m_wrap[k] = (ph == 0) && (t[k] != 0);
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (dut_d[k] !== m_d[k] || dut_idx[k] !== 6'(m_idx[k]) ||
          dut_act[k] !== (m_d[k] != 0) || dut_wrap[k] !== m_wrap[k] ||
          !$onehot0(dut_d[k])) begin
        n_err++;
        $display("FAIL model[%0d] @%0t: d=%0h want %0h idx=%0d want %0d act=%0b wrap=%0b want %0b",
                 k, $time, dut_d[k], m_d[k], dut_idx[k], m_idx[k], dut_act[k], dut_wrap[k], m_wrap[k]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  logic [3:0] exp_a[17] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                            4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1};
  logic [3:0] exp_b[13] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4,
                            4'h4, 4'h8, 4'h8, 4'h8, 4'h1};
  int wc, we;

  initial begin
    model_reset();
    #3;
    chk("reset d", 64'(d_a), 64'h0);
    chk("reset idx", 64'(idx_a), 64'h0);
    chk("reset active", 64'(act_a), 64'h0);
    chk("reset wrap", 64'(wrap_a), 64'h0);
    cycle();
    rst_n = 1'b1;
    cycle(); cycle();

    // scan sequence, with sel_vld noise that must be ignored
    en = 1'b1; mode = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cycle();
      chk("scan a d", 64'(d_a), 64'(exp_a[i]));
      chk("scan a wrap", 64'(wrap_a), 64'(i == 16));
      if (i < 13) begin
        chk("scan b d", 64'(d_b), 64'(exp_b[i]));
        chk("scan b wrap", 64'(wrap_b), 64'(i == 12));
      end
      sel = 6'd3;
      sel_vld = (i >= 2 && i < 5);
    end
    sel_vld = 1'b0;

    // mode toggling during scan is ignored
    for (int i = 0; i < 10; i++) begin
      mode = ~mode;
      cycle();
    end
    mode = 1'b1;

    // disable during the 2nd cycle of the idx=1 strobe, then restart
    en = 1'b0; cycle();
    en = 1'b1; cycle();
    repeat (5) cycle();
    chk("mid strobe d", 64'(d_a), 64'h2);
    en = 1'b0; cycle();
    chk("disable d", 64'(d_a), 64'h0);
    chk("disable active", 64'(act_a), 64'h0);
    chk("disable idx kept", 64'(idx_a), 64'h1);
    en = 1'b1;
    cycle(); chk("restart d0", 64'(d_a), 64'h1);
    cycle(); chk("restart d1", 64'(d_a), 64'h1);
    cycle(); chk("restart d2", 64'(d_a), 64'h1);
    cycle(); chk("restart gap", 64'(d_a), 64'h0);

    // switch to direct with one en=0 cycle
    en = 1'b0; mode = 1'b0; cycle();
    en = 1'b1; sel = 6'd2; cycle();
    chk("direct entry d", 64'(d_a), 64'h0);
    chk("direct entry active", 64'(act_a), 64'h0);
    sel_vld = 1'b1; cycle();
    chk("direct sel2 d", 64'(d_a), 64'h4);
    chk("direct sel2 idx", 64'(idx_a), 64'h2);
    sel = 6'd3; cycle();
    chk("direct sel3 d", 64'(d_a), 64'h8);
    chk("direct sel3 idx", 64'(idx_a), 64'h3);
    sel = 6'd1; sel_vld = 1'b0; cycle();
    chk("direct hold d", 64'(d_a), 64'h8);
    mode = 1'b1; cycle();
    chk("direct mode ignored", 64'(d_a), 64'h8);
    sel = 6'd45; sel_vld = 1'b1; cycle();
    chk("direct e sel45", d_e, 64'h1 << 45);
    sel_vld = 1'b0;

    // width sweep for SEL_W=1 and SEL_W=6
    en = 1'b0; mode = 1'b1; cycle();
    en = 1'b1; wc = 0; we = 0;
    for (int i = 0; i < 128; i++) begin
      cycle();
      wc += int'(wrap_c);
      we += int'(wrap_e);
      if (i == 0)  chk("sweep e first", d_e, 64'h1);
      if (i == 63) chk("sweep e last", d_e, 64'h8000_0000_0000_0000);
    end
    chk("sweep c wraps", 64'(wc), 64'd63);
    chk("sweep e wraps", 64'(we), 64'd1);

    // asynchronous reset mid-scan at idx=2
    en = 1'b0; cycle();
    en = 1'b1;
    repeat (10) cycle();
    chk("pre reset idx", 64'(idx_a), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async d", 64'(d_a), 64'h0);
    chk("async idx", 64'(idx_a), 64'h0);
    chk("async active", 64'(act_a), 64'h0);
    chk("async wrap", 64'(wrap_a), 64'h0);
    model_reset();
    en = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
